// File: rtl/pulse_period_monitor.sv
// Receive-side period checker for a pulse train: measures the spacing of
// rising edges and reports lock, mismatch and loss of pulse.
module pulse_period_monitor #(
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 64,
  parameter int LOCK_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic [3:0]       EXPECTED_N,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LC_V = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    TRACK
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [3:0]       r_exp;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_per_nxt;
  logic [MW-1:0]    r_match;
  logic [MW-1:0]    w_match_nxt;
  logic             w_edge;
  logic             w_cmp_en;
  logic             w_cfg_chg;
  logic             w_hit;
  logic             w_pv;
  logic             w_mm;
  logic             w_to;
  logic             w_lock_nxt;

  assign w_edge    = r_s2 & ~r_s3;
  assign w_cmp_en  = EXPECTED_N >= 4'd2;
  assign w_cfg_chg = r_exp != EXPECTED_N;
  assign w_hit     = r_cnt == CNT_W'(EXPECTED_N);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_per_nxt   = period_out;
    w_match_nxt = r_match;
    w_lock_nxt  = locked;
    w_pv        = 1'b0;
    w_mm        = 1'b0;
    w_to        = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_edge) begin
          w_state_nxt = ARMED;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ARMED, TRACK: begin
        // an edge landing on the timeout cycle still counts as a period
        if (w_edge) begin
          w_cnt_nxt   = CNT_W'(1);
          w_per_nxt   = r_cnt;
          w_pv        = 1'b1;
          w_state_nxt = TRACK;
        end else if (r_cnt == TO_V) begin
          w_to        = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          w_match_nxt = '0;
          w_lock_nxt  = 1'b0;
        end else if (r_cnt != CMAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_pv && w_cmp_en) begin
      if (w_hit) begin
        if (r_match != LC_V) begin
          w_match_nxt = r_match + MW'(1);
        end
        if (w_match_nxt == LC_V) begin
          w_lock_nxt = 1'b1;
        end
      end else begin
        w_mm        = 1'b1;
        w_match_nxt = '0;
        w_lock_nxt  = 1'b0;
      end
    end
    // new target or disabled compare: lock must re-qualify
    if (!w_cmp_en || w_cfg_chg) begin
      w_match_nxt = '0;
      w_lock_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_match      <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      mismatch     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      r_s1         <= pulse_in;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_match      <= w_match_nxt;
      period_out   <= w_per_nxt;
      period_valid <= w_pv;
      locked       <= w_lock_nxt;
      mismatch     <= w_mm;
      timeout      <= w_to;
    end
  end

  always_ff @(posedge clk) begin
    r_exp <= EXPECTED_N;
  end

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Bench for pulse_period_monitor: scenario table, directed corner
// sequences and random pulse trains against an edge-timestamp model.
module tb_pulse_period_monitor;

  localparam int CNT_W      = 8;
  localparam int TIMEOUT    = 64;
  localparam int LOCK_COUNT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pulse_in = 1'b0;
  logic [3:0]       EXPECTED_N = 4'd0;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             mismatch;
  logic             timeout;

  pulse_period_monitor #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in),
    .EXPECTED_N(EXPECTED_N), .period_out(period_out),
    .period_valid(period_valid), .locked(locked),
    .mismatch(mismatch), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_pv, n_mm, n_to;
  int last_pv_cyc, to_cyc;
  logic to_lock, pv_lock;

  // model: sampled input history, time of the reference edge,
  // and the run of matching periods since the last clearing event
  bit   vq[$];
  int   m;
  bit   have_ref;
  int   last_ref;
  int   hist[$];
  logic [3:0] e_last = 4'd0;
  logic [CNT_W-1:0] x_period;
  bit   x_pv, x_mm, x_to, x_lock;

  function automatic bit vat(int k);
    if (k < 1 || k > vq.size()) return 1'b0;
    return vq[k-1];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(bit p, logic [3:0] e, bit r);
    bit rise;
    int per;
    per  = 0;
    x_pv = 1'b0;
    x_mm = 1'b0;
    x_to = 1'b0;
    if (r) begin
      vq.delete();
      m = 0;
      have_ref = 1'b0;
      hist.delete();
      x_period = '0;
    end else begin
      vq.push_back(p);
      m++;
      // two sync stages: the edge sampled at posedge k acts at k+2
      rise = vat(m-2) && !vat(m-3);
      if (rise) begin
        if (have_ref) begin
          per      = m - last_ref;
          x_pv     = 1'b1;
          x_period = CNT_W'(per);
        end
        have_ref = 1'b1;
        last_ref = m;
      end else if (have_ref && (m - last_ref) == TIMEOUT) begin
        x_to     = 1'b1;
        have_ref = 1'b0;
        hist.delete();
      end
      if (x_pv && e >= 4'd2) begin
        if (per == int'(e)) begin
          hist.push_back(per);
          if (hist.size() > LOCK_COUNT) void'(hist.pop_front());
        end else begin
          x_mm = 1'b1;
          hist.delete();
        end
      end
      if (e < 4'd2 || e != e_last) hist.delete();
    end
    e_last = e;
    x_lock = hist.size() >= LOCK_COUNT;
  endtask

  task automatic step();
    bit p;
    logic [3:0] e;
    bit r;
    p = pulse_in;
    e = EXPECTED_N;
    r = rst;
    @(posedge clk);
    #1;
    cyc++;
    model(p, e, r);
    checks++;
    if ({period_out, period_valid, mismatch, timeout, locked} !==
        {x_period, x_pv, x_mm, x_to, x_lock}) begin
      errors++;
      $display("FAIL cycle%0d got per=%0d pv=%b mm=%b to=%b lk=%b expected per=%0d pv=%b mm=%b to=%b lk=%b",
               cyc, period_out, period_valid, mismatch, timeout, locked,
               x_period, x_pv, x_mm, x_to, x_lock);
    end
    if (period_valid === 1'b1) begin
      n_pv++;
      last_pv_cyc = cyc;
      pv_lock = locked;
    end
    if (mismatch === 1'b1) n_mm++;
    if (timeout === 1'b1) begin
      n_to++;
      to_cyc = cyc;
      to_lock = locked;
    end
  endtask

  task automatic clr();
    n_pv = 0;
    n_mm = 0;
    n_to = 0;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) begin
      pulse_in = ~pulse_in;
      step();
    end
    rst = 1'b0;
    pulse_in = 1'b0;
  endtask

  task automatic burst(int g, int n, int tail);
    for (int i = 0; i < n; i++) begin
      pulse_in = 1'b1;
      step();
      pulse_in = 1'b0;
      repeat ((i == n - 1) ? tail : g - 1) step();
    end
  endtask

  typedef struct {
    int         g;
    logic [3:0] e;
    int         n;
    int         pv;
    int         mm;
    int         to;
    bit         lk;
    int         per;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit got;
    int g, n, w;
    tbl[0]  = '{10, 4'd10, 5, 4, 0, 0, 1'b1, 10};
    tbl[1]  = '{10, 4'd10, 3, 2, 0, 0, 1'b0, 10};
    tbl[2]  = '{10, 4'd10, 4, 3, 0, 0, 1'b1, 10};
    tbl[3]  = '{ 4, 4'd10, 4, 3, 3, 0, 1'b0,  4};
    tbl[4]  = '{64, 4'd0,  3, 2, 0, 0, 1'b0, 64};
    tbl[5]  = '{65, 4'd5,  3, 0, 0, 2, 1'b0,  0};
    tbl[6]  = '{ 2, 4'd2,  5, 4, 0, 0, 1'b1,  2};
    tbl[7]  = '{15, 4'd15, 4, 3, 0, 0, 1'b1, 15};
    tbl[8]  = '{10, 4'd1,  4, 3, 0, 0, 1'b0, 10};
    tbl[9]  = '{64, 4'd15, 3, 2, 2, 0, 1'b0, 64};
    tbl[10] = '{26, 4'd10, 3, 2, 2, 0, 1'b0, 26};

    // reset held while the input toggles
    do_reset(3);
    check("rst_outputs", {period_out, period_valid, mismatch, timeout, locked}, 0);

    for (int i = 0; i < 11; i++) begin
      EXPECTED_N = tbl[i].e;
      do_reset(3);
      clr();
      burst(tbl[i].g, tbl[i].n, 1);
      repeat (5) step();
      check($sformatf("tbl%0d_pv", i), n_pv, tbl[i].pv);
      check($sformatf("tbl%0d_mm", i), n_mm, tbl[i].mm);
      check($sformatf("tbl%0d_to", i), n_to, tbl[i].to);
      check($sformatf("tbl%0d_lock", i), locked, 32'(tbl[i].lk));
      check($sformatf("tbl%0d_period", i), period_out, tbl[i].per);
    end

    // reset mid-lock, then the first edge must not report
    EXPECTED_N = 4'd10;
    do_reset(2);
    burst(10, 5, 9);
    check("prelock", locked, 1);
    do_reset(3);
    check("rst_midlock", {period_out, period_valid, mismatch, timeout, locked}, 0);
    clr();
    burst(10, 1, 9);
    check("first_edge_no_pv", n_pv, 0);

    // lock, then a short period
    clr();
    burst(10, 4, 9);
    check("lock_pv", n_pv, 4);
    check("lock_level", locked, 1);
    check("lock_no_mm", n_mm, 0);
    burst(10, 1, 3);
    pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (period_valid === 1'b1) got = 1'b1;
    end
    check("short_seen", got, 1);
    check("short_period", period_out, 4);
    check("short_mm", mismatch, 1);
    check("short_lock", locked, 0);

    // relock, then loss of pulse
    burst(10, 5, 0);
    clr();
    for (int i = 0; i < 120 && n_to == 0; i++) step();
    check("to_seen", n_to, 1);
    check("to_delay", to_cyc - last_pv_cyc, TIMEOUT);
    check("to_pre_lock", pv_lock, 1);
    check("to_lock", to_lock, 0);
    clr();
    burst(10, 1, 9);
    check("after_to_no_pv", n_pv, 0);
    burst(10, 1, 5);
    check("after_to_pv", n_pv, 1);
    check("after_to_period", period_out, 10);

    // target change while locked
    burst(10, 5, 9);
    check("cfg_prelock", locked, 1);
    EXPECTED_N = 4'd2;
    step();
    check("cfg_unlock", locked, 0);
    clr();
    burst(10, 3, 9);
    check("cfg_pv", n_pv, 3);
    check("cfg_mm", n_mm, 3);
    EXPECTED_N = 4'd0;
    clr();
    burst(10, 3, 9);
    check("dis_pv", n_pv, 3);
    check("dis_mm", n_mm, 0);
    check("dis_lock", locked, 0);
    check("dis_period", period_out, 10);

    // stuck-high input: one edge, then loss
    clr();
    pulse_in = 1'b1;
    repeat (80) step();
    check("stuck_high_to", n_to, 1);
    pulse_in = 1'b0;

    // random trains against the model
    for (int b = 0; b < 60; b++) begin
      g = $urandom_range(2, 70);
      n = $urandom_range(2, 6);
      if ($urandom_range(0, 3) == 0) EXPECTED_N = 4'($urandom_range(0, 15));
      else if (g <= 15) EXPECTED_N = 4'(g);
      else EXPECTED_N = 4'($urandom_range(2, 15));
      if ($urandom_range(0, 15) == 0) do_reset(2);
      for (int i = 0; i < n; i++) begin
        w = $urandom_range(1, g - 1);
        if ($urandom_range(0, 9) == 0) EXPECTED_N = 4'($urandom_range(0, 15));
        pulse_in = 1'b1;
        repeat (w) step();
        pulse_in = 1'b0;
        repeat (g - w) step();
      end
    end
    repeat (80) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
